// File: rtl/riscv_core_dpath_pipe_muldiv.sv
// Four-stage (X -> M -> X2 -> X3) pipelined RISC-V multiply/divide unit.
// X->M takes operand magnitudes, M->X2 does the unsigned core op, X2->X3 fixes signs and packs.
module riscv_core_dpath_pipe_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,
  output logic [63:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,
  input  logic        stall_Xhl,
  input  logic        stall_Mhl,
  input  logic        stall_X2hl,
  input  logic        stall_X3hl
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 2 * XLEN;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef struct packed {
    logic [2:0]      fn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } x_pay_t;

  typedef struct packed {
    logic [2:0]      fn;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_q;
    logic            neg_r;
    logic            div0;
    logic [XLEN-1:0] a;
  } m_pay_t;

  typedef struct packed {
    logic [2:0]      fn;
    logic [DLEN-1:0] raw;
    logic            neg_q;
    logic            neg_r;
    logic            div0;
    logic [XLEN-1:0] a;
  } x2_pay_t;

  logic            val_x, val_m, val_x2, val_x3;
  x_pay_t          x_q;
  m_pay_t          m_q, m_d;
  x2_pay_t         x2_q, x2_d;
  logic [DLEN-1:0] res_x3, res_d;

  logic hold_x, hold_m, hold_x2, hold_x3;
  logic adv_x, adv_m, adv_x2;
  logic is_signed_x, is_div_x;
  logic [XLEN-1:0] quo_x2, rem_x2;

  // Hold chain: a valid stage blocks behind a held successor; empty stages never block.
  always_comb begin
    hold_x3 = (val_x3 && !muldivresp_rdy) || stall_X3hl;
    hold_x2 = stall_X2hl || (hold_x3 && val_x2);
    hold_m  = stall_Mhl  || (hold_x2 && val_m);
    hold_x  = stall_Xhl  || (hold_m  && val_x);
    adv_x   = val_x  && !hold_x;
    adv_m   = val_m  && !hold_m;
    adv_x2  = val_x2 && !hold_x2;
  end

  assign muldivreq_rdy         = !hold_x;
  assign muldivresp_val        = val_x3;
  assign muldivresp_msg_result = res_x3;

  // X -> M: classify the op and take operand magnitudes for the unsigned core.
  always_comb begin
    m_d         = '0;
    is_signed_x = x_q.fn inside {FN_MUL, FN_DIV, FN_REM};
    is_div_x    = x_q.fn inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
    m_d.fn      = x_q.fn;
    m_d.a       = x_q.a;
    m_d.mag_a   = (is_signed_x && x_q.a[XLEN-1]) ? -x_q.a : x_q.a;
    m_d.mag_b   = (is_signed_x && x_q.b[XLEN-1]) ? -x_q.b : x_q.b;
    m_d.neg_q   = is_signed_x && (x_q.a[XLEN-1] ^ x_q.b[XLEN-1]);
    m_d.neg_r   = is_signed_x && x_q.a[XLEN-1];
    m_d.div0    = is_div_x && (x_q.b == '0);
  end

  // M -> X2: unsigned multiply or divide on magnitudes; zero divisors are patched later.
  always_comb begin
    x2_d       = '0;
    x2_d.fn    = m_q.fn;
    x2_d.neg_q = m_q.neg_q;
    x2_d.neg_r = m_q.neg_r;
    x2_d.div0  = m_q.div0;
    x2_d.a     = m_q.a;
    if (m_q.fn == FN_MUL) begin
      x2_d.raw = DLEN'(m_q.mag_a) * DLEN'(m_q.mag_b);
    end else if (m_q.mag_b != '0) begin
      x2_d.raw = {m_q.mag_a % m_q.mag_b, m_q.mag_a / m_q.mag_b};
    end
  end

  // X2 -> X3: restore signs and pack {remainder, quotient}; signed overflow falls out naturally.
  always_comb begin
    res_d  = '0;
    quo_x2 = x2_q.raw[XLEN-1:0];
    rem_x2 = x2_q.raw[DLEN-1:XLEN];
    unique case (x2_q.fn)
      FN_MUL: res_d = x2_q.neg_q ? -x2_q.raw : x2_q.raw;
      FN_DIV, FN_DIVU, FN_REM, FN_REMU: begin
        if (x2_q.div0) begin
          res_d = {x2_q.a, {XLEN{1'b1}}};
        end else begin
          res_d = {x2_q.neg_r ? -rem_x2 : rem_x2, x2_q.neg_q ? -quo_x2 : quo_x2};
        end
      end
      default: res_d = '0;
    endcase
  end

  // Pipeline registers; payloads only load when a valid op advances into the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_x  <= 1'b0;
      val_m  <= 1'b0;
      val_x2 <= 1'b0;
      val_x3 <= 1'b0;
      x_q    <= '0;
      m_q    <= '0;
      x2_q   <= '0;
      res_x3 <= '0;
    end else begin
      if (!hold_x) begin
        val_x <= muldivreq_val;
        if (muldivreq_val) begin
          x_q <= x_pay_t'({muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b});
        end
      end
      if (!hold_m) begin
        val_m <= adv_x;
        if (adv_x) begin
          m_q <= m_d;
        end
      end
      if (!hold_x2) begin
        val_x2 <= adv_m;
        if (adv_m) begin
          x2_q <= x2_d;
        end
      end
      if (!hold_x3) begin
        val_x3 <= adv_x2;
        if (adv_x2) begin
          res_x3 <= res_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_dpath_pipe_muldiv.sv
// Self-checking bench for riscv_core_dpath_pipe_muldiv: directed vectors, latency,
// backpressure, random streams with stalls, and mid-flight reset, against a queue model.
module tb_riscv_core_dpath_pipe_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fn;
  logic [31:0] a, b;
  logic        req_val, req_rdy;
  logic [63:0] result;
  logic        resp_val, resp_rdy;
  logic        fb_mode;
  logic [3:0]  rnd_stall;
  logic        stall_x, stall_m, stall_x2, stall_x3;

  int n_total = 0;
  int n_pass  = 0;
  int n_acc   = 0;
  int n_resp  = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
  } vec_t;

  always #5 clk = ~clk;

  assign stall_x  = rnd_stall[0] | (fb_mode & resp_val & ~resp_rdy);
  assign stall_m  = rnd_stall[1] | (fb_mode & resp_val & ~resp_rdy);
  assign stall_x2 = rnd_stall[2];
  assign stall_x3 = rnd_stall[3];

  riscv_core_dpath_pipe_muldiv dut (
    .clk                   (clk),
    .reset                 (reset),
    .muldivreq_msg_fn      (fn),
    .muldivreq_msg_a       (a),
    .muldivreq_msg_b       (b),
    .muldivreq_val         (req_val),
    .muldivreq_rdy         (req_rdy),
    .muldivresp_msg_result (result),
    .muldivresp_val        (resp_val),
    .muldivresp_rdy        (resp_rdy),
    .stall_Xhl             (stall_x),
    .stall_Mhl             (stall_m),
    .stall_X2hl            (stall_x2),
    .stall_X3hl            (stall_x3)
  );

  // Reference arithmetic using the simulator's own signed/unsigned operators.
  function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    longint p;
    int     sq, sr;
    case (f)
      3'd0: begin
        p = longint'(int'(x)) * longint'(int'(y));
        return 64'(p);
      end
      3'd1, 3'd3: begin
        if (y == 32'h0) return {x, 32'hffff_ffff};
        if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
        sq = int'(x) / int'(y);
        sr = int'(x) % int'(y);
        return {32'(sr), 32'(sq)};
      end
      3'd2, 3'd4: begin
        if (y == 32'h0) return {x, 32'hffff_ffff};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (caller sits just after a rising edge); returns just after the accept edge.
  task automatic send(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    fn = f; a = x; b = y; req_val = 1'b1;
    do begin
      @(negedge clk);
      got = req_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 500);
    req_val = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL send_timeout: got rdy=0 expected rdy=1 within 500 cycles");
    end
  endtask

  task automatic wait_resp(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_val && k < 20);
    if (!resp_val) begin
      n_total++;
      $display("FAIL resp_timeout: got no response expected one within 20 cycles");
    end
  endtask

  // Random request stream against a random sink, optionally with random stage stalls.
  task automatic run_stream(input int n, input bit rand_stall);
    int target, guard, sel;
    bit src_done;
    logic [31:0] x, y;
    target = n_resp + n;
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(0, 3)) step();
          x = $urandom;
          y = $urandom;
          sel = $urandom_range(0, 7);
          if (sel == 0) y = 32'h0;
          if (sel == 1) begin x = 32'h8000_0000; y = 32'hffff_ffff; end
          if (sel == 2) y = 32'($urandom_range(1, 300));
          send(3'($urandom_range(0, 7)), x, y);
        end
        src_done = 1'b1;
      end
      begin
        guard = 0;
        while ((!src_done || n_resp < target) && guard < 4000) begin
          step();
          resp_rdy = ($urandom_range(0, 2) != 0);
          if (rand_stall) begin
            rnd_stall[2:0] = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            rnd_stall[3]   = ($urandom_range(0, 3) == 0) && !resp_val;
          end
          guard++;
        end
        resp_rdy  = 1'b1;
        rnd_stall = '0;
      end
    join
    check("stream_count", 64'(n_resp), 64'(target));
    check("stream_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [0:14];
    int          k, n0, cnt;
    logic [63:0] e0;

    vecs = '{
      '{3'd0, 32'hffff_ffff, 32'h0000_0001, 64'hffff_ffff_ffff_ffff},
      '{3'd0, 32'hffff_fff8, 32'hffff_fff8, 64'h0000_0000_0000_0040},
      '{3'd0, 32'hdead_beef, 32'h1000_0000, 64'hfdea_dbee_f000_0000},
      '{3'd1, 32'h0a01_b044, 32'hffff_b14a, 64'h0000_3372_ffff_df75},
      '{3'd1, 32'hdead_beef, 32'h0000_beef, 64'hffff_da72_ffff_d353},
      '{3'd3, 32'hf5fe_4fbc, 32'hffff_b14a, 64'hffff_cc8e_0000_208b},
      '{3'd2, 32'hdead_beef, 32'h0000_beef, 64'h0000_227f_0001_2a90},
      '{3'd4, 32'hf5fe_4fbc, 32'hffff_b14a, 64'hf5fe_4fbc_0000_0000},
      '{3'd2, 32'h0000_0222, 32'h0000_002a, 64'h0000_0000_0000_000d},
      '{3'd1, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_ffff_ffff},
      '{3'd1, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000},
      '{3'd3, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000},
      '{3'd4, 32'h0000_0abc, 32'h0000_0000, 64'h0000_0abc_ffff_ffff},
      '{3'd5, 32'h0000_0007, 32'h0000_0003, 64'h0000_0000_0000_0000},
      '{3'd7, 32'hffff_ffff, 32'hffff_ffff, 64'h0000_0000_0000_0000}
    };

    reset = 1'b1; fn = '0; a = '0; b = '0; req_val = 1'b0; resp_rdy = 1'b1;
    fb_mode = 1'b0; rnd_stall = '0;

    // Scoreboard: every cycle the response is valid it must match the oldest accepted op.
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_q.delete();
        end else begin
          if (resp_val) begin
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL spurious_resp: got response %h expected none", result);
            end else begin
              check("resp_result", result, exp_q[0]);
              if (resp_rdy) begin
                void'(exp_q.pop_front());
                n_resp++;
              end
            end
          end
          if (req_val && req_rdy) begin
            exp_q.push_back(model(fn, a, b));
            n_acc++;
          end
        end
      end
    join_none

    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_val", 64'(resp_val), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd1);
    check("rst_result", result, 64'h0);

    step();
    send(3'd0, 32'h7, 32'h6);
    wait_resp(k);
    check("latency", 64'(k), 64'd4);
    check("latency_result", result, 64'd42);
    step();

    for (int i = 0; i < 15; i++) begin
      check($sformatf("model_pin_%0d", i), model(vecs[i].f, vecs[i].x, vecs[i].y), vecs[i].e);
      send(vecs[i].f, vecs[i].x, vecs[i].y);
      wait_resp(k);
      check($sformatf("directed_%0d", i), result, vecs[i].e);
      step();
    end

    // Backpressure: with the sink stalled the pipe holds exactly four ops, then blocks.
    resp_rdy = 1'b0;
    n0 = n_acc;
    req_val = 1'b1;
    repeat (8) begin
      fn = 3'($urandom_range(0, 4)); a = $urandom; b = $urandom;
      step();
    end
    @(negedge clk);
    check("bp_fill", 64'(n_acc - n0), 64'd4);
    check("bp_rdy", 64'(req_rdy), 64'd0);
    check("bp_val", 64'(resp_val), 64'd1);
    e0 = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", result, e0);
    end
    step();
    req_val = 1'b0;
    resp_rdy = 1'b1;
    k = 0;
    while (n_resp != n_acc && k < 50) begin
      step();
      k++;
    end
    check("bp_drain", 64'(n_resp), 64'(n_acc));

    fb_mode = 1'b1;
    step();
    run_stream(12, 1'b0);
    step();
    run_stream(40, 1'b1);

    // Reset with three ops in flight: nothing may come out afterwards.
    step();
    send(3'd0, 32'h3, 32'h5);
    send(3'd1, 32'h64, 32'h7);
    send(3'd2, 32'hffff_0000, 32'h10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_req_rdy", 64'(req_rdy), 64'd1);
    check("midrst_result", result, 64'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_val) cnt++;
      @(negedge clk);
    end
    check("midrst_no_resp", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
